// File: rtl/bus_mux_stom_routed_if.sv
// Handshake and serial-line bundle for bus_mux_stom_routed; master modport is the arbiter side.
// Optional STOM_TIMEOUT_EN adds the o_route_tout watchdog pulse.
interface bus_mux_stom_routed_if #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1
);
  logic                  i_route_req;
  logic [M_ID_WIDTH-1:0] i_master_sel;
  logic [S_ID_WIDTH-1:0] i_slave_sel;
  logic                  i_route_rel;
  logic                  o_route_ack;
  logic                  o_route_err;
  logic                  o_route_busy;
  logic [NO_SLAVES-1:0]  i_slave;
  logic [NO_MASTERS-1:0] o_master;
`ifdef STOM_TIMEOUT_EN
  logic                  o_route_tout;
`endif

  modport master (
    output i_route_req, i_master_sel, i_slave_sel, i_route_rel, i_slave,
    input  o_route_ack, o_route_err, o_route_busy, o_master
`ifdef STOM_TIMEOUT_EN
    , input o_route_tout
`endif
  );

  modport slave (
    input  i_route_req, i_master_sel, i_slave_sel, i_route_rel, i_slave,
    output o_route_ack, o_route_err, o_route_busy, o_master
`ifdef STOM_TIMEOUT_EN
    , output o_route_tout
`endif
  );
endinterface

// File: rtl/bus_mux_stom_routed.sv
// Registered slave-to-master return-path router with guard cycles around each route.
// Define STOM_TIMEOUT_EN to add a watchdog that releases a route whose slave line stays static.
module bus_mux_stom_routed #(
  parameter int   NO_MASTERS   = 2,
  parameter int   NO_SLAVES    = 3,
  parameter int   S_ID_WIDTH   = $clog2(NO_SLAVES + 1),
  parameter int   M_ID_WIDTH   = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
  parameter int   GUARD_CYCLES = 2,
  parameter logic IDLE_LEVEL   = 1'b1
`ifdef STOM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                  clk,
  input logic                  rst,
  bus_mux_stom_routed_if.slave io_bus
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ROUTE, ST_DRAIN} state_t;

  state_t                r_state;
  logic [M_ID_WIDTH-1:0] r_mId;
  logic [S_ID_WIDTH-1:0] r_sId;
  logic [GW-1:0]         r_guardCnt;
  logic [NO_MASTERS-1:0] r_master;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_reqValid;
  logic                  w_slaveBit;
  logic [NO_MASTERS-1:0] w_routed;
  logic [GW-1:0]         w_guardNext;
  logic                  w_timeout;

  assign w_reqValid = (int'(io_bus.i_slave_sel) != 0) &&
                      (int'(io_bus.i_slave_sel) <= NO_SLAVES) &&
                      (int'(io_bus.i_master_sel) < NO_MASTERS);

  assign w_guardNext = (r_guardCnt == GUARD_MAX) ? r_guardCnt : r_guardCnt + 1'b1;

  // Slave IDs are 1-based; ID 0 never matches so the selected bit stays 0.
  always_comb begin
    w_slaveBit = 1'b0;
    for (int i = 0; i < NO_SLAVES; i++) begin
      if (r_sId == S_ID_WIDTH'(i + 1)) w_slaveBit = io_bus.i_slave[i];
    end
    for (int j = 0; j < NO_MASTERS; j++) begin
      w_routed[j] = (r_mId == M_ID_WIDTH'(j)) ? w_slaveBit : IDLE_LEVEL;
    end
  end

`ifdef STOM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_toutCnt;
  logic          r_prevSlave;
  logic          r_tout;
  logic          w_edge;

  assign w_edge    = (w_slaveBit != r_prevSlave);
  assign w_timeout = (r_state == ST_ROUTE) && !w_edge && (r_toutCnt == TW'(TIMEOUT_CYCLES - 1));
  assign io_bus.o_route_tout = r_tout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toutCnt   <= '0;
      r_prevSlave <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_tout      <= w_timeout && !io_bus.i_route_rel;
      r_prevSlave <= w_slaveBit;
      if (r_state != ST_ROUTE || w_edge) r_toutCnt <= '0;
      else                               r_toutCnt <= r_toutCnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mId      <= '0;
      r_sId      <= '0;
      r_guardCnt <= '0;
      r_master   <= {NO_MASTERS{IDLE_LEVEL}};
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= io_bus.i_route_req && (r_busy || !w_reqValid);
      case (r_state)
        ST_IDLE: begin
          if (io_bus.i_route_req && w_reqValid) begin
            r_mId      <= io_bus.i_master_sel;
            r_sId      <= io_bus.i_slave_sel;
            r_busy     <= 1'b1;
            r_guardCnt <= '0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_guardCnt == GUARD_LAST) begin
            r_ack   <= 1'b1;
            r_state <= ST_ROUTE;
          end else begin
            r_guardCnt <= w_guardNext;
          end
        end
        // Release (or watchdog) idles the line on the very next cycle.
        ST_ROUTE: begin
          if (io_bus.i_route_rel || w_timeout) begin
            r_master   <= {NO_MASTERS{IDLE_LEVEL}};
            r_guardCnt <= '0;
            r_state    <= ST_DRAIN;
          end else begin
            r_master <= w_routed;
          end
        end
        ST_DRAIN: begin
          if (r_guardCnt == GUARD_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_guardCnt <= w_guardNext;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.o_master     = r_master;
  assign io_bus.o_route_ack  = r_ack;
  assign io_bus.o_route_err  = r_err;
  assign io_bus.o_route_busy = r_busy;
endmodule

// File: tb/tb_bus_mux_stom_routed.sv
// Directed bench for bus_mux_stom_routed: status is {master[1:0], busy, ack, err}.
module tb_bus_mux_stom_routed;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bus_mux_stom_routed_if #(.NO_MASTERS(2), .NO_SLAVES(3)) busIf ();

  bus_mux_stom_routed dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (busIf.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] getStatus();
    return {busIf.o_master, busIf.o_route_busy, busIf.o_route_ack, busIf.o_route_err};
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [0:0] m, input logic [1:0] s,
                               input logic rel, input logic [2:0] sl);
    busIf.i_route_req  = req;
    busIf.i_master_sel = m;
    busIf.i_slave_sel  = s;
    busIf.i_route_rel  = rel;
    busIf.i_slave      = sl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pattern;
    logic [3:0]  nibble;
    pattern = 16'hA5C3;
    nibble  = 4'b0110;

    // Reset held three cycles with slaves low: masters idle high, no flags.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("reset", getStatus(), 5'b11_000);
    end
    rst = 1'b0;

    // Route slave 2 to master 1 through two guard cycles.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 3'b000);
    step();
    checkOutput("setup1", getStatus(), 5'b11_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("setup2", getStatus(), 5'b11_100);
    step();
    checkOutput("ack", getStatus(), 5'b11_110);

    // Unselected slaves carry the inverse so a wrong selection shows up.
    for (int i = 15; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, {~pattern[i], pattern[i], ~pattern[i]});
      step();
      checkOutput("route", getStatus(), {pattern[i], 1'b1, 3'b100});
    end

    // Request while busy is rejected and the active route is untouched.
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 3'b101);
    step();
    checkOutput("busyReqErr", getStatus(), 5'b01_101);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b010);
    step();
    checkOutput("busyReqKeep", getStatus(), 5'b11_100);

    // Release: two drain cycles at idle level, busy drops on the third.
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 3'b000);
    step();
    checkOutput("drain1", getStatus(), 5'b11_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("drain2", getStatus(), 5'b11_100);
    step();
    checkOutput("idleAfterDrain", getStatus(), 5'b11_000);

    // Slave ID 0 is invalid for either master.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("badSlaveM0", getStatus(), 5'b11_001);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("badSlaveM1", getStatus(), 5'b11_001);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("errCleared", getStatus(), 5'b11_000);

    // Request and release together in IDLE: request wins; release in SETUP ignored.
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b1, 3'b000);
    step();
    checkOutput("reqWinsSetup1", getStatus(), 5'b11_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 3'b000);
    step();
    checkOutput("relInSetup", getStatus(), 5'b11_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("ack2", getStatus(), 5'b11_110);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, {nibble[i], ~nibble[i], ~nibble[i]});
      step();
      checkOutput("route2", getStatus(), {1'b1, nibble[i], 3'b100});
    end

    // Reset in the middle of a route returns everything to idle at once.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000);
    step();
    checkOutput("midRouteRst", getStatus(), 5'b11_000);
    rst = 1'b0;
    step();
    checkOutput("afterRst", getStatus(), 5'b11_000);

    // A fresh request is accepted immediately, confirming the FSM is in IDLE.
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 3'b000);
    step();
    checkOutput("reqAfterRst", getStatus(), 5'b11_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b110);
    step();
    checkOutput("setupAfterRst", getStatus(), 5'b11_100);
    step();
    checkOutput("ack3", getStatus(), 5'b11_110);
    step();
    checkOutput("route3", getStatus(), 5'b01_100);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 3'b110);
    step();
    checkOutput("drain3", getStatus(), 5'b11_100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
